// File: rtl/cache_mem_pkg.sv
// Shared parameters and state encoding for the cache line transfer engine.
package cache_mem_pkg;

  localparam int ADDR_W         = 32;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = 16;
  localparam int LINE_W         = WORD_W * WORDS_PER_LINE;
  localparam int OFF_W          = $clog2(LINE_W / 8);

  // Engine sequencing: idle, one memory beat per word, one response cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cache_line_buf.sv
// One cache line of storage: full-line load, single-word write, single-word read.
module cache_line_buf #(
  parameter int WORD_W         = cache_mem_pkg::WORD_W,
  parameter int WORDS_PER_LINE = cache_mem_pkg::WORDS_PER_LINE,
  localparam int LINE_W        = WORD_W * WORDS_PER_LINE,
  localparam int IDX_W         = $clog2(WORDS_PER_LINE)
) (
  input  logic              clk,
  input  logic              load_line,
  input  logic [LINE_W-1:0] load_data,
  input  logic              wr_word,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [WORD_W-1:0] rd_word,
  output logic [LINE_W-1:0] line
);

  logic [LINE_W-1:0] line_q;
  logic [LINE_W-1:0] line_d;

  // Next line contents: a full load wins over a single-word write.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    line_d = line_q;
    if (load_line) begin
      line_d = load_data;
    end else if (wr_word) begin
      line_d[wr_idx*WORD_W +: WORD_W] = wr_data;
    end
  end

  // Line storage register.
  always_ff @(posedge clk) begin
    // NOTE: the data buffer has no reset; every transfer overwrites it before any word is consumed.
    line_q <= line_d;
  end

  assign rd_word = line_q[rd_idx*WORD_W +: WORD_W];
  assign line    = line_q;

endmodule

// File: rtl/cache_line_mem_if.sv
// Line transfer engine between the L1 controller and a word-wide memory bus.
// A refill reads WORDS_PER_LINE beats into the line buffer and returns the line;
// a writeback streams the latched line out as beats and returns a completion.
module cache_line_mem_if #(
  parameter int ADDR_W         = cache_mem_pkg::ADDR_W,
  parameter int WORD_W         = cache_mem_pkg::WORD_W,
  parameter int WORDS_PER_LINE = cache_mem_pkg::WORDS_PER_LINE,
  localparam int LINE_W        = WORD_W * WORDS_PER_LINE,
  localparam int OFF_W         = $clog2(LINE_W / 8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LINE_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_we,
  output logic [LINE_W-1:0] resp_data,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              busy
);

  import cache_mem_pkg::*;

  localparam int BEAT_W     = $clog2(WORDS_PER_LINE);
  localparam int BYTE_SHIFT = $clog2(WORD_W / 8);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK  = (ADDR_W'(1) << OFF_W) - ADDR_W'(1);

  state_e              state_q,     state_d;
  logic [BEAT_W-1:0]   beat_q,      beat_d;
  logic [ADDR_W-1:0]   base_q,      base_d;
  logic                we_q,        we_d;
  logic [LINE_W-1:0]   resp_data_q, resp_data_d;

  logic                buf_load;
  logic                buf_wr;
  logic [WORD_W-1:0]   buf_rd_word;
  logic [LINE_W-1:0]   buf_line;
  logic [LINE_W-1:0]   refill_line;
  logic                in_beat;
  logic                beat_done;

  cache_line_buf #(
    .WORD_W         (WORD_W),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_line_buf (
    .clk       (clk),
    .load_line (buf_load),
    .load_data (req_wdata),
    .wr_word   (buf_wr),
    .wr_idx    (beat_q),
    .wr_data   (mem_rdata),
    .rd_idx    (beat_q),
    .rd_word   (buf_rd_word),
    .line      (buf_line)
  );

  assign in_beat   = (state_q == BEAT);
  assign beat_done = in_beat && mem_ready;

  // Completed refill line: buffer contents with the final beat's read data merged in,
  // so the response can be registered on the same edge the last word arrives.
  always_comb begin
    refill_line = buf_line;
    refill_line[beat_q*WORD_W +: WORD_W] = mem_rdata;
  end

  // Sequencing: accept in IDLE, one word per completed beat, one response cycle.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    base_d      = base_q;
    we_d        = we_q;
    resp_data_d = resp_data_q;
    buf_load    = 1'b0;
    buf_wr      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          base_d   = req_addr & ~OFF_MASK;
          we_d     = req_we;
          buf_load = 1'b1;
          beat_d   = '0;
          state_d  = BEAT;
        end
      end
      BEAT: begin
        if (beat_done) begin
          buf_wr = !we_q;
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
            // Writebacks leave the last refilled line visible to the controller.
            if (!we_q) begin
              resp_data_d = refill_line;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Engine state registers with synchronous active-low reset; reset aborts any transfer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      base_q      <= '0;
      we_q        <= 1'b0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      base_q      <= base_d;
      we_q        <= we_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Outputs are decoded from registered state only, so they stay stable through stalls.
  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign mem_valid  = in_beat;
  assign mem_we     = in_beat && we_q;
  assign mem_addr   = in_beat ? (base_q | (ADDR_W'(beat_q) << BYTE_SHIFT)) : '0;
  assign mem_wdata  = (in_beat && we_q) ? buf_rd_word : '0;
  assign resp_valid = (state_q == DONE);
  assign resp_we    = (state_q == DONE) && we_q;
  assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_cache_line_mem_if.sv
// Self-checking bench for cache_line_mem_if: directed scenarios with literal
// expectations plus a randomized run checked every cycle against a line-level model.
module tb_cache_line_mem_if;

  localparam int AW = 32;
  localparam int WW = 32;
  localparam int NW = 16;
  localparam int LW = WW * NW;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_wdata;
  logic          resp_valid;
  logic          resp_we;
  logic [LW-1:0] resp_data;
  logic          mem_valid;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_wdata;
  logic          mem_ready;
  logic [WW-1:0] mem_rdata;
  logic          busy;

  int errors = 0;
  int checks = 0;

  cache_line_mem_if dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_we    (resp_we),
    .resp_data  (resp_data),
    .mem_valid  (mem_valid),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  // phase: -1 idle, 0..NW-1 = index of the word being transferred, NW = response cycle.
  int            exp_phase = -1;
  logic [AW-1:0] exp_base;
  logic          exp_we;
  logic [WW-1:0] exp_line [NW];
  logic [LW-1:0] exp_resp;
  bit            model_ok = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      exp_phase = -1;
      exp_resp  = '0;
      model_ok  = 1'b1;
    end else if (model_ok) begin
      if (exp_phase == -1) begin
        if (req_valid) begin
          exp_base = (req_addr / 64) * 64;
          exp_we   = req_we;
          for (int k = 0; k < NW; k++) exp_line[k] = req_wdata[k*WW +: WW];
          exp_phase = 0;
        end
      end else if (exp_phase < NW) begin
        if (mem_ready) begin
          if (!exp_we) exp_line[exp_phase] = mem_rdata;
          exp_phase++;
          if (exp_phase == NW && !exp_we)
            for (int k = 0; k < NW; k++) exp_resp[k*WW +: WW] = exp_line[k];
        end
      end else begin
        exp_phase = -1;
      end
    end
  end

  // Compare every DUT output against the model, mid-cycle.
  always @(negedge clk) begin
    if (model_ok) begin
      bit in_xfer;
      in_xfer = (exp_phase >= 0) && (exp_phase < NW);
      check("req_ready", req_ready, exp_phase == -1);
      check("busy", busy, exp_phase != -1);
      check("mem_valid", mem_valid, in_xfer);
      check("mem_we", mem_we, in_xfer && exp_we);
      check("mem_addr", mem_addr, in_xfer ? exp_base + AW'(exp_phase * 4) : '0);
      check("mem_wdata", mem_wdata, (in_xfer && exp_we) ? exp_line[exp_phase] : '0);
      check("resp_valid", resp_valid, exp_phase == NW);
      check("resp_we", resp_we, (exp_phase == NW) && exp_we);
      check("resp_data", resp_data, exp_resp);
    end
  end

  // ---------------- read data driver ----------------
  bit rd_directed = 1'b1;

  initial begin
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rd_directed) mem_rdata = 32'hA000_0000 + WW'(exp_phase);
      else             mem_rdata = $urandom;
    end
  end

  // ---------------- stimulus ----------------
  logic [LW-1:0] line_a;
  int            cyc;

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    mem_ready = 1'b1;
    step();
    step();
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_mem_valid", mem_valid, 1'b0);
    check("rst_resp_data", resp_data, '0);
    reset = 1'b1;
    step();

    // Refill at 0x1234 with mem_ready tied high.
    for (int k = 0; k < NW; k++) line_a[k*WW +: WW] = 32'hA000_0000 + k;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_1234; req_wdata = '1;
    step();                                   // accept edge -> cycle 1
    req_valid = 1'b0;
    for (int k = 0; k < NW; k++) begin
      check("refill_addr", mem_addr, 32'h0000_1200 + 4 * k);
      check("refill_we", mem_we, 1'b0);
      step();
    end
    check("refill_lat_valid", resp_valid, 1'b1);   // cycle 17
    check("refill_resp_we", resp_we, 1'b0);
    check("refill_data", resp_data, line_a);
    step();

    // Writeback at 0x8040.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_8040;
    for (int k = 0; k < NW; k++) req_wdata[k*WW +: WW] = 32'h5500_0000 + k;
    step();
    req_valid = 1'b0;
    for (int k = 0; k < NW; k++) begin
      check("wb_addr", mem_addr, 32'h0000_8040 + 4 * k);
      check("wb_we", mem_we, 1'b1);
      check("wb_wdata", mem_wdata, 32'h5500_0000 + k);
      step();
    end
    check("wb_resp_valid", resp_valid, 1'b1);
    check("wb_resp_we", resp_we, 1'b1);
    check("wb_resp_data_kept", resp_data, line_a);
    step();

    // Refill stalled for three cycles at beat 5.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_2000;
    step();
    req_valid = 1'b0;
    repeat (5) step();                        // cycle 6, beat 5 presented
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_addr", mem_addr, 32'h0000_2014);
      check("stall_valid", mem_valid, 1'b1);
      step();
    end
    mem_ready = 1'b1;
    cyc = 9;
    while (!resp_valid && cyc < 60) begin
      step();
      cyc++;
    end
    check("stall_latency", cyc, 20);
    check("stall_data", resp_data, line_a);
    step();

    // Request held while busy is only accepted after the response.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_3000;
    step();
    req_we = 1'b0; req_addr = 32'h0000_4444;
    cyc = 1;
    while (!resp_valid && cyc < 40) begin
      check("busy_not_ready", req_ready, 1'b0);
      step();
      cyc++;
    end
    check("busy_first_done", resp_valid, 1'b1);
    step();
    check("busy_idle_ready", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    check("busy_second_accepted", busy, 1'b1);
    check("busy_second_addr", mem_addr, 32'h0000_4440);
    cyc = 1;
    while (!resp_valid && cyc < 40) begin
      step();
      cyc++;
    end
    check("busy_second_done", resp_valid, 1'b1);
    step();

    // Reset during beat 8 of a refill.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_5000;
    step();
    req_valid = 1'b0;
    repeat (8) step();
    check("midrst_pre_addr", mem_addr, 32'h0000_5020);
    reset = 1'b0;
    step();
    check("midrst_mem_valid", mem_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_req_ready", req_ready, 1'b1);
    check("midrst_resp_data", resp_data, '0);
    reset = 1'b1;
    repeat (25) begin
      step();
      check("midrst_no_resp", resp_valid, 1'b0);
    end

    // Randomized traffic, checked by the compare process each cycle.
    rd_directed = 1'b0;
    repeat (4000) begin
      reset     = ($urandom_range(0, 499) != 0);
      req_valid = ($urandom_range(0, 2) == 0);
      req_we    = $urandom_range(0, 1);
      req_addr  = $urandom;
      for (int k = 0; k < NW; k++) req_wdata[k*WW +: WW] = $urandom;
      mem_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    reset = 1'b1;
    req_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_line_mem_if.md
Name: cache_line_mem_if

Overview:
- Line-transfer engine directly downstream of the L1 cache controller FSM.
- Services the controller's writeback (dirty-line evict) and refill (line read) requests.
- Splits each cache line into word beats on a simple valid/ready main-memory bus.
- Returns the assembled line (refill) or a completion (writeback) to the controller.

Parameters:
- ADDR_W, 32, byte address width.
- WORD_W, 32, memory bus data width in bits.
- WORDS_PER_LINE, 16, beats per line; power of two.
- LINE_W, WORD_W*WORDS_PER_LINE (localparam, 512), line width in bits.
- OFF_W, log2(LINE_W/8) (localparam, 6), byte-offset bits within a line.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  controller request valid.
- req_ready  out  1  engine can accept a request.
- req_we  in  1  1 = writeback, 0 = refill.
- req_addr  in  ADDR_W  line address; low OFF_W bits ignored.
- req_wdata  in  LINE_W  line to write back; word k = bits [k*WORD_W +: WORD_W].
- resp_valid  out  1  one-cycle completion pulse.
- resp_we  out  1  echo of req_we of the completed request.
- resp_data  out  LINE_W  refilled line (same word packing as req_wdata).
- mem_valid  out  1  beat valid to memory.
- mem_we  out  1  beat is a write.
- mem_addr  out  ADDR_W  word-aligned beat address.
- mem_wdata  out  WORD_W  write beat data.
- mem_ready  in  1  memory accepts / completes the beat.
- mem_rdata  in  WORD_W  read data; valid in the cycle mem_valid && mem_ready.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: reset sampled low at a clk edge gives the following state:
  - State: IDLE. Beat counter: 0.
  - Outputs low: req_ready=1 (IDLE), resp_valid=0, resp_we=0, resp_data=0, mem_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0.
- States: IDLE, BEAT, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid: latch the request. Line base = {req_addr[ADDR_W-1:OFF_W], OFF_W'b0}; also latch req_we and req_wdata into the line buffer.
  - Clear the beat counter, go to BEAT.
- BEAT:
  - mem_valid=1, mem_we = latched we.
  - mem_addr = line base + beat*(WORD_W/8).
  - mem_wdata = buffer word[beat] (writeback; don't-care 0 on refill).
  - A beat completes when mem_valid && mem_ready. On completion:
    - Refill: write mem_rdata into buffer word[beat].
    - Increment the beat counter.
    - After the last beat (WORDS_PER_LINE-1), go to DONE.
  - Stall: mem_ready low holds mem_valid, mem_addr, mem_we and mem_wdata stable. mem_valid never drops mid-line.
- DONE:
  - resp_valid=1 for exactly one cycle; resp_we = latched we.
  - resp_data = buffer, but only updated for refills. It holds its value until the next refill completes.
  - Next state: IDLE.
- Latency: with mem_ready tied high, the accept edge is cycle 0, beats occupy cycles 1..16, and resp_valid is high in cycle 17.
- Back-to-back requests: the earliest next accept is the cycle after DONE (one IDLE cycle).
- Requests while busy: req_ready=0, so req_valid is ignored. The controller must hold the request until it is accepted.
- Beat counter: log2(WORDS_PER_LINE) bits, wraps to 0 after the last beat (no overflow state).
- Address: wrap-around of the line base at the top of the address space is not special-cased. Beats stay inside the line because offsets are OR'd into the low OFF_W bits.
- Reset mid-operation:
  - Aborts immediately; mem_valid=0 on the next cycle.
  - The partial line is discarded and no resp_valid is produced.
  - resp_data resets to 0.
- mem_ready while mem_valid=0 is ignored.

Decomposition:
- Package cache_mem_pkg holds:
  - ADDR_W, WORD_W, WORDS_PER_LINE, LINE_W, OFF_W defaults.
  - State encoding enum (IDLE=2'd0, BEAT=2'd1, DONE=2'd2).
- One sub-module, cache_line_buf:
  - LINE_W register with load_line (full-line load), wr_word (indexed word write) and a rd_word indexed read port.
  - Full-line output drives resp_data.

Test Plan:
- Refill, mem_ready=1, req_addr=0x0000_1234, mem_rdata = 0xA000_0000+beat:
  - mem_addr steps 0x1200, 0x1204 … 0x123C with mem_we=0.
  - resp_valid in cycle 17, resp_we=0.
  - resp_data word k = 0xA000_0000+k.
- Writeback, req_addr=0x0000_8040, req_wdata word k = 0x5500_0000+k, mem_ready=1:
  - 16 beats, mem_we=1, mem_addr 0x8040..0x807C, mem_wdata = 0x5500_0000+k.
  - resp_valid with resp_we=1; resp_data unchanged from the prior refill.
- Stall: refill with mem_ready low for 3 cycles at beat 5:
  - mem_addr stays 0x…14 and mem_valid stays 1 for the stall.
  - Total latency 20 cycles; data is correct.
- Busy rejection: a second req_valid during beats 0..15 sees req_ready=0 and is not accepted. It is accepted in the IDLE cycle after resp_valid.
- Reset mid-line: reset=0 during beat 8 of a refill.
  - Next cycle: mem_valid=0, busy=0, req_ready=1, resp_data=0.
  - No resp_valid is ever issued for the aborted request.
